// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
// Holds the frame state encoding, oversampling ratio and default stop length.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int OVERSAMPLE      = 16;
  localparam int DEFAULT_SB_TICK = 16;
  // 5 bits covers stop lengths up to 32 oversample ticks.
  localparam int TICK_W          = 5;

endpackage

// File: rtl/baud_gen.sv
// Oversample tick divider: one-cycle tick every BAUD_DIV clocks.
// The counter is free-running; clr restarts it so a frame's bit timing starts at the pop.
module baud_gen
#(
  parameter int BAUD_DIV = 326
)
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

  logic [DIV_W-1:0] cnt_r;

  // Divider counter: 0..BAUD_DIV-1, restarted on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (cnt_r == DIV_LAST) begin
      cnt_r <= {DIV_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + DIV_W'(1);
    end
  end

  assign tick = (cnt_r == DIV_LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// 8N1 serial transmitter that pops words from a first-word-fall-through FIFO
// and frames them as start, DBIT data bits LSB first, and a stop bit on tx.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int B        = 8,
  parameter int DBIT     = 8,
  parameter int SB_TICK  = DEFAULT_SB_TICK,
  parameter int BAUD_DIV = 326
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         fifo_empty,
  input  logic [B-1:0] fifo_r_data,
  output logic         fifo_rd,
  output logic         tx,
  output logic         tx_busy
);

  localparam int BIT_W = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DBIT - 1);

  tx_state_e         state_r, state_next_s;
  logic [TICK_W-1:0] tick_cnt_r, tick_cnt_next_s;
  logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_next_s;
  logic [DBIT-1:0]   shift_r, shift_next_s;
  logic              tx_r, tx_next_s;
  logic              tx_busy_r;
  logic              pop_s;
  logic              tick_s;

  baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (pop_s),
    .tick (tick_s)
  );

  // Next-state, counter and shift-register logic for the frame FSM.
  always_comb begin
    state_next_s    = state_r;
    tick_cnt_next_s = tick_cnt_r;
    bit_cnt_next_s  = bit_cnt_r;
    shift_next_s    = shift_r;
    pop_s           = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty && !rst) begin
          pop_s           = 1'b1;
          shift_next_s    = fifo_r_data[DBIT-1:0];
          tick_cnt_next_s = {TICK_W{1'b0}};
          bit_cnt_next_s  = {BIT_W{1'b0}};
          state_next_s    = START;
        end else begin
          state_next_s    = IDLE;
        end
      end
      START: begin
        if (tick_s && (tick_cnt_r == OS_LAST)) begin
          tick_cnt_next_s = {TICK_W{1'b0}};
          state_next_s    = DATA;
        end else if (tick_s) begin
          tick_cnt_next_s = tick_cnt_r + TICK_W'(1);
        end else begin
          tick_cnt_next_s = tick_cnt_r;
        end
      end
      DATA: begin
        if (tick_s && (tick_cnt_r == OS_LAST)) begin
          tick_cnt_next_s = {TICK_W{1'b0}};
          shift_next_s    = shift_r >> 1;
          if (bit_cnt_r == BIT_LAST) begin
            state_next_s   = STOP;
          end else begin
            bit_cnt_next_s = bit_cnt_r + BIT_W'(1);
          end
        end else if (tick_s) begin
          tick_cnt_next_s = tick_cnt_r + TICK_W'(1);
        end else begin
          tick_cnt_next_s = tick_cnt_r;
        end
      end
      STOP: begin
        if (tick_s && (tick_cnt_r == STOP_LAST)) begin
          tick_cnt_next_s = {TICK_W{1'b0}};
          state_next_s    = IDLE;
        end else if (tick_s) begin
          tick_cnt_next_s = tick_cnt_r + TICK_W'(1);
        end else begin
          tick_cnt_next_s = tick_cnt_r;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Line level follows the state being entered so tx changes on the pop edge.
  always_comb begin
    tx_next_s = 1'b1;
    case (state_next_s)
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      default: tx_next_s = 1'b1;
    endcase
  end

  // State, counters and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      tick_cnt_r <= {TICK_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      shift_r    <= {DBIT{1'b0}};
      tx_r       <= 1'b1;
      tx_busy_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      tick_cnt_r <= tick_cnt_next_s;
      bit_cnt_r  <= bit_cnt_next_s;
      shift_r    <= shift_next_s;
      tx_r       <= tx_next_s;
      tx_busy_r  <= (state_next_s != IDLE);
    end
  end

  assign fifo_rd = pop_s;
  assign tx      = tx_r;
  assign tx_busy = tx_busy_r;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with BAUD_DIV=4 (64-clock bits) and a small
// first-word-fall-through FIFO model feeding it.
module tb_uart_tx_fifo_drain;

  localparam int BIT_CLKS   = 64;
  localparam int WAIT_LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_r_data;
  logic       fifo_rd;
  logic       tx;
  logic       tx_busy;

  logic [7:0] fmem [4];
  logic [2:0] wp = 3'd0;
  logic [2:0] rp = 3'd0;

  int n_checks = 0;
  int n_fail = 0;
  int pop_cnt = 0;
  int rd_empty_cnt = 0;
  int rd_busy_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_drain #(
    .B        (8),
    .DBIT     (8),
    .SB_TICK  (16),
    .BAUD_DIV (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_r_data (fifo_r_data),
    .fifo_rd     (fifo_rd),
    .tx          (tx),
    .tx_busy     (tx_busy)
  );

  // Four-deep fall-through FIFO; not cleared by the transmitter's reset.
  assign fifo_empty  = (wp == rp);
  assign fifo_full   = (3'(wp - rp) == 3'd4);
  assign fifo_r_data = fmem[rp[1:0]];

  always @(posedge clk) begin
    if (wr && !fifo_full) begin
      fmem[wp[1:0]] <= w_data;
      wp <= wp + 3'd1;
    end
    if (fifo_rd && !fifo_empty) begin
      rp <= rp + 3'd1;
    end
  end

  always @(negedge clk) begin
    if (fifo_rd === 1'b1) begin
      pop_cnt++;
      if (fifo_empty) rd_empty_cnt++;
      if (tx_busy) rd_busy_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the write edge.
  task automatic fifo_write(input logic [7:0] d);
    w_data = d;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Counts idle-high negedges until the start bit is seen.
  task automatic wait_start(output int waited);
    waited = 0;
    @(negedge clk);
    while (tx !== 1'b0 && waited < WAIT_LIMIT) begin
      waited++;
      @(negedge clk);
    end
  endtask

  // Current negedge is offset 0 of the start bit; ends on the last stop-bit negedge.
  task automatic check_frame(input logic [7:0] exp, input string tag);
    logic [9:0] bits;
    logic [7:0] got;
    int bad;
    bits = {1'b1, exp, 1'b0};
    got = 8'h00;
    bad = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (tx !== bits[b] || tx_busy !== 1'b1) bad++;
        if (c == BIT_CLKS / 2 && b >= 1 && b <= 8) got[b-1] = tx;
      end
    end
    check_eq({tag, "_data"}, {24'h0, got}, {24'h0, exp});
    check_eq({tag, "_timing"}, bad, 0);
  endtask

  initial begin
    int w;
    int bad;
    int p0;
    logic [7:0] fill_data [4];
    fill_data[0] = 8'h11;
    fill_data[1] = 8'h22;
    fill_data[2] = 8'h33;
    fill_data[3] = 8'h44;

    // Reset with FIFO empty, then a quiet idle line.
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_rd", fifo_rd, 0);
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_rd !== 1'b0) bad++;
    end
    check_eq("idle_quiet", bad, 0);

    // Single byte 8'hDA.
    p0 = pop_cnt;
    fifo_write(8'hDA);
    check_eq("da_rd", fifo_rd, 1);
    check_eq("da_tx_pre", tx, 1);
    wait_start(w);
    check_eq("da_latency", w, 0);
    check_frame(8'hDA, "da");
    repeat (2) @(negedge clk);
    check_eq("da_empty", fifo_empty, 1);
    #1 check_eq("da_pops", pop_cnt - p0, 1);

    // Back-to-back 31/0E/E1.
    @(negedge clk);
    p0 = pop_cnt;
    fifo_write(8'h31);
    fork
      begin
        int w0;
        wait_start(w0);
        check_eq("b2b_lat", w0, 0);
        check_frame(8'h31, "b2b0");
      end
      begin
        fifo_write(8'h0E);
        fifo_write(8'hE1);
      end
    join
    wait_start(w);
    check_eq("b2b_gap1", w, 1);
    check_frame(8'h0E, "b2b1");
    wait_start(w);
    check_eq("b2b_gap2", w, 1);
    check_frame(8'hE1, "b2b2");
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check_eq("b2b_no_extra", bad, 0);
    check_eq("b2b_empty", fifo_empty, 1);
    #1 check_eq("b2b_pops", pop_cnt - p0, 3);

    // Fill until full while the first frame is on the line.
    @(negedge clk);
    fifo_write(8'hA5);
    wait_start(w);
    fork
      check_frame(8'hA5, "fill0");
      begin
        int n;
        n = 0;
        while (!fifo_full && n < 8) begin
          fifo_write(fill_data[n % 4]);
          n++;
        end
        check_eq("fill_count", n, 4);
      end
    join
    check_eq("full_held", fifo_full, 1);
    @(negedge clk);
    check_eq("full_pop_rd", fifo_rd, 1);
    check_eq("full_at_pop", fifo_full, 1);
    @(negedge clk);
    check_eq("full_released", fifo_full, 0);
    check_eq("fill1_start", tx, 0);
    check_frame(8'h11, "fill1");
    for (int i = 1; i < 4; i++) begin
      wait_start(w);
      check_eq("fill_gap", w, 1);
      check_frame(fill_data[i], "fill_n");
    end
    repeat (2) @(negedge clk);
    check_eq("fill_empty", fifo_empty, 1);

    // Write lands on the edge that ends STOP.
    @(negedge clk);
    fifo_write(8'h5A);
    wait_start(w);
    #1 p0 = pop_cnt;
    fork
      check_frame(8'h5A, "stopw0");
      begin
        repeat (BIT_CLKS * 10 - 1) @(negedge clk);
        check_eq("stopw_no_early_rd", fifo_rd, 0);
        w_data = 8'hC3;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
      end
    join
    check_eq("stopw_idle_rd", fifo_rd, 1);
    check_eq("stopw_idle_tx", tx, 1);
    #1 check_eq("stopw_pops", pop_cnt - p0, 1);
    @(negedge clk);
    check_eq("stopw_start", tx, 0);
    check_frame(8'hC3, "stopw1");

    // Reset mid-DATA of 8'hE1 with 8'h31 queued behind it.
    repeat (4) @(negedge clk);
    fifo_write(8'hE1);
    fork
      begin
        int w1;
        wait_start(w1);
        repeat (150) @(negedge clk);
        check_eq("mid_pre_tx", tx, 0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_tx", tx, 1);
        check_eq("mid_rst_busy", tx_busy, 0);
        check_eq("mid_rst_rd", fifo_rd, 0);
      end
      fifo_write(8'h31);
    join
    @(negedge clk);
    rst = 1'b0;
    wait_start(w);
    check_eq("mid_restart_lat", w, 0);
    check_frame(8'h31, "mid_after");
    repeat (2) @(negedge clk);
    check_eq("mid_empty", fifo_empty, 1);

    check_eq("rd_while_empty", rd_empty_cnt, 0);
    check_eq("rd_while_busy", rd_busy_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

Serial transmitter that sits directly downstream of the team's byte FIFO. Whenever the FIFO is non-empty it pops one word, frames it as 8N1 asynchronous serial (start bit, DBIT data bits LSB first, stop bit) and drives it on `tx`. It uses 16× oversampling ticks from an internal baud divider, so bit timing is exact and independent of FIFO activity.

## Interface
- `B`, 8: FIFO word width; must equal the FIFO's `B`.
- `DBIT`, 8: data bits per frame, 1..B; bits above DBIT-1 of the popped word are ignored.
- `SB_TICK`, 16: stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- `BAUD_DIV`, 326: clock cycles per oversample tick, ≥2 (50 MHz / (16·9600) ≈ 326).

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset; **one clock; reset is asynchronous and active-high**.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_r_data`  in  B  FIFO head word, valid whenever `fifo_empty`=0 (first-word fall-through).
- `fifo_rd`  out  1  pop strobe to FIFO `rd`; one-cycle pulse per frame.
- `tx`  out  1  serial line, idle high.
- `tx_busy`  out  1  high from the pop cycle's next edge until return to IDLE.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE: `tx`=1. If `fifo_empty`=0: `fifo_rd`=1 this cycle (combinational from state==IDLE && !fifo_empty), `fifo_r_data[DBIT-1:0]` latched into shift register, tick counter, bit counter and baud divider cleared, next state START.
- START: `tx`=0; after 16 ticks go to DATA.
- DATA: `tx`=shift[0]; every 16 ticks shift right by one and increment bit counter; after bit DBIT-1 completes, go to STOP.
- STOP: `tx`=1; after SB_TICK ticks go to IDLE.
- `fifo_rd` is never high outside IDLE and never high while `fifo_empty`=1.
- Word width: tick counter 5 bits (covers SB_TICK ≤ 32), bit counter $clog2(DBIT) bits, divider $clog2(BAUD_DIV) bits; all counters wrap only via explicit clear.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `fifo_rd`=0, state IDLE, all counters 0. `rst` asserted mid-frame aborts immediately (async); FIFO word already popped is lost; after release a new frame starts only from IDLE.
- `tx` and `tx_busy` are registered. `tx` goes low on the edge that ends the `fifo_rd` cycle.
- Tick: divider counts 0..BAUD_DIV-1, pulses for one cycle at BAUD_DIV-1; free-running except cleared on pop. Bit period exactly 16·BAUD_DIV clocks.
- Frame: start + data = (1+DBIT)·16·BAUD_DIV clocks; stop = SB_TICK·BAUD_DIV clocks, plus 1 IDLE clock when back-to-back (minimum inter-frame overhead = 1 clock).
- Pop-to-tx-low latency: 1 clock. FIFO becoming non-empty in the cycle STOP ends: popped on the following IDLE cycle.
- Simultaneous FIFO write into an empty FIFO: pop only after `fifo_empty` deasserts; no speculative reads.

## Structure
- Package `uart_pkg`: state enum (IDLE, START, DATA, STOP), `OVERSAMPLE`=16 constant, default `SB_TICK`.
- Sub-module `baud_gen` (params `BAUD_DIV`; ports `clk`, `rst`, `clr`, `tick`): the divider. FSM, shift register and counters live in the top.

## Test plan
All with `BAUD_DIV`=4 (bit period 64 clocks), DBIT=8, SB_TICK=16, driven from the real FIFO.
- Reset: assert `rst` with FIFO empty → `tx`=1, `tx_busy`=0, `fifo_rd`=0; no change over 1000 clocks.
- Single byte 8'hDA written → one `fifo_rd` pulse; `tx` = 0, then 0,1,0,1,1,0,1,1 (64 clocks each), then 1 for 64 clocks; `fifo_empty` returns 1.
- Back-to-back 8'h31, 8'h0E, 8'hE1 → exactly 3 `fifo_rd` pulses, frames decode to 31/0E/E1 in order, each frame 640 clocks, 1-clock gap between stop and next start.
- Fill FIFO until `full` then stop writing → FIFO drains in order; `full` deasserts one clock after first `fifo_rd`; no pop while empty.
- Reset mid-DATA of 8'hE1 → `tx`=1 within same cycle, state IDLE; next queued byte 8'h31 transmits as a clean full frame after release.
- Write arriving during STOP of previous frame → popped on first IDLE cycle, not earlier.
